// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified RAM between the RV32I core's
// instruction-fetch port and its load/store port.
//
// Data requests have fixed priority over fetches. Each memory transaction
// uses a req/ready handshake for the request and rvalid for read data. The
// arbiter also handles RV32I sub-word accesses: byte-enable generation,
// store-lane replication, and load extraction with sign or zero extension.
//
// Ports
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   if_req/if_addr           fetch request (held until if_valid), word address
//   if_rdata/if_valid        fetched word plus a one-cycle done pulse
//   d_req/d_we/d_addr        data request (held until d_valid), store flag,
//                            byte address
//   d_wdata/d_funct3         store data and RV32I load/store funct3
//   d_rdata/d_valid/d_err    extended load data, done pulse, misalign flag
//   busy                     transaction in progress (grant .. valid pulse)
//   mem_req/mem_we/mem_addr  memory request, write, word address
//   mem_be/mem_wdata         byte enables, lane-replicated store data
//   mem_ready/mem_rvalid     memory accept strobe, read data valid
//   mem_rdata                memory read data
//
// Optional feature macro: MEM_ARB_MISALIGN_CHK_EN
//   Defined: a misaligned halfword or word data access issues no memory
//   transaction and completes with d_valid=d_err=1 and d_rdata=0.
//   Undefined: d_err stays 0 and misaligned accesses go to memory as-is.

module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [2:0]        d_funct3,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              d_err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, IF_REQ, IF_WAIT, D_REQ, D_WAIT, D_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]        off_q, off_d;     // byte offset of the latched data access
  logic [2:0]        f3_q, f3_d;       // funct3 of the latched data access
  logic              if_valid_q, if_valid_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              d_valid_q, d_valid_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;
  logic              busy_q, busy_d;
  logic              misaligned;

  // Store byte enables selected by access size and byte offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    if (f3[1])
      return 4'hF;
    else if (f3[0])
      return 4'b0011 << {off[1], 1'b0};
    else
      return 4'b0001 << off;
  endfunction

  // Replicate the significant store bits across every lane they could land in.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    if (f3[1])
      return wd;
    else if (f3[0])
      return {2{wd[15:0]}};
    else
      return {4{wd[7:0]}};
  endfunction

  // Move the addressed bytes down to bit 0, then extend by funct3.
  // Halfword loads shift by a[1] only.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rd);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    sh_b = rd >> {off, 3'b000};
    sh_h = rd >> {off[1], 4'b0000};
    case (f3)
      3'b000:  return {{24{sh_b[7]}}, sh_b[7:0]};
      3'b001:  return {{16{sh_h[15]}}, sh_h[15:0]};
      3'b100:  return {24'h0, sh_b[7:0]};
      3'b101:  return {16'h0, sh_h[15:0]};
      default: return sh_b;
    endcase
  endfunction

`ifdef MEM_ARB_MISALIGN_CHK_EN
  assign misaligned = (d_funct3[1:0] == 2'b01 && d_addr[0]) ||
                      (d_funct3[1] && d_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    off_d       = off_q;
    f3_d        = f3_q;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_valid_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // A requester still showing req during its own valid pulse is
        // finishing, not asking again, so it is masked for that cycle.
        if (d_req && !d_valid_q) begin
          off_d = d_addr[1:0];
          f3_d  = d_funct3;
          if (misaligned) begin
            state_d   = D_DONE;
            d_valid_d = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = 32'h0;
          end else begin
            state_d     = D_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr & WORD_MASK;
            mem_be_d    = d_we ? store_be(d_funct3, d_addr[1:0]) : 4'hF;
            mem_wdata_d = d_we ? store_lanes(d_funct3, d_wdata) : 32'h0;
          end
        end else if (if_req && !if_valid_q) begin
          state_d     = IF_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr & WORD_MASK;
          mem_be_d    = 4'hF;
          mem_wdata_d = 32'h0;
        end
      end
      IF_REQ: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = IF_WAIT;
        end
      end
      D_REQ: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d   = D_DONE;
            d_valid_d = 1'b1;
          end else begin
            state_d = D_WAIT;
          end
        end
      end
      IF_WAIT: begin
        if (mem_rvalid) begin
          if_rdata_d = mem_rdata;
          if_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      D_WAIT: begin
        if (mem_rvalid) begin
          d_rdata_d = load_extract(f3_q, off_q, mem_rdata);
          d_valid_d = 1'b1;
          state_d   = IDLE;
        end
      end
      D_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Reads pulse valid after returning to IDLE, so busy also covers that cycle.
    busy_d = (state_d != IDLE) || if_valid_d || d_valid_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= 32'h0;
      d_err_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_valid_q   <= d_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign busy      = busy_q;

endmodule
